// File: rtl/seq_pkg.sv
// Shared definitions for the frame-level stage sequencer.
// Holds the FSM state encoding, the stage index width and the default
// watchdog limit used by stage_sequencer and seq_watchdog.
package seq_pkg;

    localparam int          STAGE_IDX_W            = 3;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 2000000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_START  = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog counter for the stage sequencer.
// Counts cycles while enabled and flags the cycle in which the count has
// reached LIMIT-1, i.e. the LIMIT-th enabled cycle since the last clear.
// LIMIT=0 disables the timeout output entirely.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   i_clr      clear counter to 0 (takes priority over i_en)
//   i_en       count this cycle
//   o_timeout  high while enabled and the count equals LIMIT-1
module seq_watchdog #(
    parameter int unsigned LIMIT = 100,
    parameter int unsigned WIDTH = 22
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam logic [WIDTH-1:0] LIMIT_M1 = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (LIMIT != 0) && i_en && (r_count == LIMIT_M1);

endmodule

// File: rtl/stage_sequencer.sv
// Frame-level controller that launches the image-processing stages in
// order, one frame at a time: wait for the stage's ready gate, pulse its
// start for one cycle, wait for its end-of-frame pulse, move on.
// Offers busy/done/error status, continuous frame mode and a per-stage
// watchdog.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   frame_start    pulse, start one frame (IDLE only)
//   continuous     level, relaunch stage 0 after DONE
//   abort          pulse, back to IDLE (clears ERROR too)
//   clear_error    pulse, leave ERROR
//   stage_ready    per-stage launch gate
//   stage_endf     per-stage end-of-frame pulse
//   stage_start    one-hot single-cycle start pulse
//   busy           high in LAUNCH/START/RUN/DONE
//   cur_stage      stage being launched or run
//   frame_done     single-cycle pulse per finished frame
//   error          watchdog error (ERROR state)
//   err_stage      stage index captured on timeout
//   frame_count    completed frames, wrapping
//
// state  | meaning
// IDLE   | waiting for frame_start
// LAUNCH | waiting for stage_ready[cur_stage]
// START  | stage_start[cur_stage] pulsed, watchdog cleared
// RUN    | waiting for stage_endf[cur_stage], watchdog counting
// DONE   | frame complete for one cycle, frame_done pulsed
// ERROR  | watchdog expired, waiting for clear_error/abort
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES      = 2,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES,
    parameter int unsigned TO_WIDTH        = 22,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       continuous,
    input  logic                       abort,
    input  logic                       clear_error,
    input  logic [NUM_STAGES-1:0]      stage_ready,
    input  logic [NUM_STAGES-1:0]      stage_endf,
    output logic [NUM_STAGES-1:0]      stage_start,
    output logic                       busy,
    output logic [STAGE_IDX_W-1:0]     cur_stage,
    output logic                       frame_done,
    output logic                       error,
    output logic [STAGE_IDX_W-1:0]     err_stage,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam logic [NUM_STAGES-1:0]  ONE_HOT0 = 1;
    localparam logic [STAGE_IDX_W-1:0] LAST_IDX = STAGE_IDX_W'(NUM_STAGES - 1);

    seq_state_t                 r_state;
    logic [STAGE_IDX_W-1:0]     r_cur_stage;
    logic [NUM_STAGES-1:0]      r_stage_start;
    logic                       r_busy;
    logic                       r_frame_done;
    logic                       r_error;
    logic [STAGE_IDX_W-1:0]     r_err_stage;
    logic [FRAME_CNT_WIDTH-1:0] r_frame_count;

    logic [NUM_STAGES-1:0]      w_cur_onehot;
    logic                       w_ready_cur;
    logic                       w_endf_cur;
    logic                       w_last;
    logic                       w_timeout;

    // Masking with the one-hot of cur_stage keeps the other stages' bits
    // out of the decision and avoids an out-of-range index.
    assign w_cur_onehot = ONE_HOT0 << r_cur_stage;
    assign w_ready_cur  = |(stage_ready & w_cur_onehot);
    assign w_endf_cur   = |(stage_endf & w_cur_onehot);
    assign w_last       = (r_cur_stage == LAST_IDX);

    seq_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (r_state == S_START),
        .i_en      (r_state == S_RUN),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cur_stage   <= '0;
            r_stage_start <= '0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_error       <= 1'b0;
            r_err_stage   <= '0;
            r_frame_count <= '0;
        end else begin
            r_stage_start <= '0;
            r_frame_done  <= 1'b0;

            if (abort) begin
                // Abort outranks everything; in ERROR it doubles as clear.
                r_state     <= S_IDLE;
                r_cur_stage <= '0;
                r_busy      <= 1'b0;
                r_error     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (frame_start) begin
                            r_state     <= S_LAUNCH;
                            r_cur_stage <= '0;
                            r_busy      <= 1'b1;
                        end
                    end
                    S_LAUNCH: begin
                        if (w_ready_cur) begin
                            r_state       <= S_START;
                            r_stage_start <= w_cur_onehot;
                        end
                    end
                    S_START: begin
                        r_state <= S_RUN;
                    end
                    S_RUN: begin
                        // endf beats a timeout in the same cycle.
                        if (w_endf_cur) begin
                            if (w_last) begin
                                r_state       <= S_DONE;
                                r_frame_done  <= 1'b1;
                                r_frame_count <= r_frame_count + 1'b1;
                            end else begin
                                r_state     <= S_LAUNCH;
                                r_cur_stage <= r_cur_stage + 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_state     <= S_ERROR;
                            r_busy      <= 1'b0;
                            r_error     <= 1'b1;
                            r_err_stage <= r_cur_stage;
                        end
                    end
                    S_DONE: begin
                        r_cur_stage <= '0;
                        if (continuous) begin
                            r_state <= S_LAUNCH;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    S_ERROR: begin
                        if (clear_error) begin
                            r_state     <= S_IDLE;
                            r_cur_stage <= '0;
                            r_error     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_cur_stage <= '0;
                        r_busy      <= 1'b0;
                        r_error     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stage_start = r_stage_start;
    assign busy        = r_busy;
    assign cur_stage   = r_cur_stage;
    assign frame_done  = r_frame_done;
    assign error       = r_error;
    assign err_stage   = r_err_stage;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with NUM_STAGES=2, TIMEOUT_CYCLES=100
// and a 2-bit frame counter so that counter wrap is reachable.
// Inputs change and outputs are sampled at the falling edge; the DUT acts
// on the rising edge in the middle of each bench cycle.
module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       continuous = 1'b0;
    logic       abort = 1'b0;
    logic       clear_error = 1'b0;
    logic [1:0] stage_ready = 2'b00;
    logic [1:0] stage_endf = 2'b00;
    logic [1:0] stage_start;
    logic       busy;
    logic [2:0] cur_stage;
    logic       frame_done;
    logic       error;
    logic [2:0] err_stage;
    logic [1:0] frame_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    stage_sequencer #(
        .NUM_STAGES      (2),
        .TIMEOUT_CYCLES  (100),
        .TO_WIDTH        (8),
        .FRAME_CNT_WIDTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .continuous  (continuous),
        .abort       (abort),
        .clear_error (clear_error),
        .stage_ready (stage_ready),
        .stage_endf  (stage_endf),
        .stage_start (stage_start),
        .busy        (busy),
        .cur_stage   (cur_stage),
        .frame_done  (frame_done),
        .error       (error),
        .err_stage   (err_stage),
        .frame_count (frame_count)
    );

    task automatic tick();
        @(negedge clk);
        cyc++;
        frame_start = 1'b0;
        abort       = 1'b0;
        clear_error = 1'b0;
        stage_endf  = 2'b00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Returns the cycle in which stage_start equals mask, or -1 on budget expiry.
    task automatic wait_start(input logic [1:0] mask, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (stage_start == mask) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int t0, ts, te, tf, tr, at, bad;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_stage_start", stage_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_stage", err_stage, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_cur_stage", cur_stage, 0);
        rst = 1'b0;

        // ---------------- test 1: basic frame ----------------
        stage_ready = 2'b11;
        tick();
        frame_start = 1'b1;
        t0 = cyc;
        wait_start(2'b01, 10, ts);
        chk("t1_start0_latency", ts - t0, 2);
        tick();
        chk("t1_start_width", stage_start, 0);
        chk("t1_busy_run", busy, 1);
        repeat (5) tick();
        tick();
        stage_endf = 2'b01;
        te = cyc;
        wait_start(2'b10, 10, at);
        chk("t1_start1_latency", at - te, 2);
        chk("t1_cur_stage1", cur_stage, 1);
        repeat (4) tick();
        tick();
        stage_endf = 2'b10;
        tick();
        chk("t1_frame_done", frame_done, 1);
        chk("t1_frame_count", frame_count, 1);
        chk("t1_busy_done", busy, 1);
        tick();
        chk("t1_done_width", frame_done, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_cur_stage_idle", cur_stage, 0);

        // ---------------- test 2: ready gate, no timeout in LAUNCH ----------------
        do_reset();
        stage_ready = 2'b01;
        tick();
        frame_start = 1'b1;
        t0 = cyc;
        wait_start(2'b01, 10, ts);
        chk("t2_start0_latency", ts - t0, 2);
        repeat (5) tick();
        stage_endf = 2'b01;
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (stage_start != 2'b00 || error != 1'b0) bad++;
        end
        chk("t2_launch_quiet", bad, 0);
        chk("t2_cur_stage_wait", cur_stage, 1);
        chk("t2_busy_wait", busy, 1);
        stage_ready = 2'b11;
        tr = cyc;
        wait_start(2'b10, 10, at);
        chk("t2_start1_after_ready", at - tr, 1);
        repeat (3) tick();
        stage_endf = 2'b10;
        tick();
        chk("t2_frame_done", frame_done, 1);
        chk("t2_frame_count", frame_count, 1);

        // ---------------- test 3: watchdog on stage 0 ----------------
        do_reset();
        stage_ready = 2'b11;
        tick();
        frame_start = 1'b1;
        wait_start(2'b01, 10, ts);
        te = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (error) begin
                te = cyc;
                break;
            end
        end
        // START at ts, 100 RUN cycles (count 0..99), ERROR in ts+101
        chk("t3_timeout_cycle", te - ts, 101);
        chk("t3_err_stage", err_stage, 0);
        chk("t3_busy_error", busy, 0);
        frame_start = 1'b1;
        tick();
        chk("t3_ignore_frame_start", error, 1);
        chk("t3_no_launch", busy, 0);
        clear_error = 1'b1;
        tick();
        chk("t3_cleared", error, 0);
        chk("t3_err_stage_hold", err_stage, 0);
        chk("t3_idle_busy", busy, 0);

        // watchdog on stage 1, leave ERROR through abort
        frame_start = 1'b1;
        wait_start(2'b01, 10, ts);
        tick();
        stage_endf = 2'b01;
        wait_start(2'b10, 10, ts);
        te = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (error) begin
                te = cyc;
                break;
            end
        end
        chk("t3b_timeout_cycle", te - ts, 101);
        chk("t3b_err_stage", err_stage, 1);
        abort = 1'b1;
        tick();
        chk("t3b_abort_clears", error, 0);
        chk("t3b_err_stage_hold", err_stage, 1);

        // endf in the timeout cycle wins
        frame_start = 1'b1;
        wait_start(2'b01, 10, ts);
        for (int i = 0; i < 100; i++) tick();
        stage_endf = 2'b01;
        te = cyc;
        wait_start(2'b10, 10, at);
        chk("t3c_endf_beats_timeout", at - te, 2);
        chk("t3c_no_error", error, 0);

        // ---------------- test 4: continuous mode and counter wrap ----------------
        do_reset();
        stage_ready = 2'b11;
        continuous = 1'b1;
        tick();
        frame_start = 1'b1;
        t0 = cyc;
        wait_start(2'b01, 10, ts);
        chk("t4_first_start", ts - t0, 2);
        for (int f = 0; f < 3; f++) begin
            repeat (3) tick();
            stage_endf = 2'b01;
            wait_start(2'b10, 10, at);
            repeat (3) tick();
            if (f == 2) continuous = 1'b0;
            stage_endf = 2'b10;
            tf = cyc;
            tick();
            chk("t4_frame_done", frame_done, 1);
            chk("t4_frame_count", frame_count, f + 1);
            if (f < 2) begin
                // DONE -> LAUNCH -> START
                wait_start(2'b01, 10, ts);
                chk("t4_relaunch", ts - tf, 3);
            end
        end
        tick();
        chk("t4_final_idle", busy, 0);
        chk("t4_count3", frame_count, 3);
        frame_start = 1'b1;
        wait_start(2'b01, 10, ts);
        tick();
        stage_endf = 2'b01;
        wait_start(2'b10, 10, at);
        tick();
        stage_endf = 2'b10;
        tick();
        chk("t4_count_wrap", frame_count, 0);

        // ---------------- test 5: abort with endf[1] ----------------
        do_reset();
        stage_ready = 2'b11;
        tick();
        frame_start = 1'b1;
        wait_start(2'b01, 10, ts);
        tick();
        stage_endf = 2'b01;
        wait_start(2'b10, 10, at);
        repeat (2) tick();
        stage_endf = 2'b10;
        abort = 1'b1;
        tick();
        chk("t5_no_frame_done", frame_done, 0);
        chk("t5_busy_low", busy, 0);
        chk("t5_cur_stage0", cur_stage, 0);
        chk("t5_count_same", frame_count, 0);
        tick();
        frame_start = 1'b1;
        t0 = cyc;
        wait_start(2'b01, 10, ts);
        chk("t5_restart", ts - t0, 2);

        // ---------------- test 6: ignored pulses ----------------
        do_reset();
        stage_ready = 2'b11;
        tick();
        frame_start = 1'b1;
        wait_start(2'b01, 10, ts);
        stage_endf = 2'b01;     // endf in START: ignored
        frame_start = 1'b1;     // busy: dropped
        tick();
        stage_endf = 2'b10;     // other stage: ignored
        tick();
        frame_start = 1'b1;
        repeat (4) tick();
        chk("t6_still_stage0", cur_stage, 0);
        chk("t6_still_busy", busy, 1);
        chk("t6_no_start", stage_start, 0);
        stage_endf = 2'b01;
        te = cyc;
        wait_start(2'b10, 10, at);
        chk("t6_start1_latency", at - te, 2);
        repeat (2) tick();
        stage_endf = 2'b10;
        tick();
        chk("t6_frame_count", frame_count, 1);
        repeat (5) tick();
        chk("t6_not_queued", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
